spi_word_fifo: RTL and testbench
================================

Name: spi_word_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO of AXI-width words.
- Two instances sit between the AXI register slave and spi_controller:
  - spi_command_buffer: AXI writes, controller pops.
  - spi_read_buffer: controller pushes, AXI pops.
- FWFT is mandatory: the controller samples dout in the same cycle it asserts rd_en, so the head word must already be valid whenever empty=0.
- Provides occupancy count, almost-full flag, sticky overflow/underflow error flags and a synchronous flush.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, word width in bits.
- DEPTH, 16, number of word entries; power of two, 2 to 256.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1 to DEPTH.

Ports:
- axi_clk  in  1  clock; all logic on rising edge.
- reset_b  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents.
- clr_err  in  1  synchronous clear of the sticky error flags.
- wr_en  in  1  push request.
- din  in  C_S_AXI_DATA_WIDTH  push data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_LEVEL.
- rd_en  in  1  pop request.
- dout  out  C_S_AXI_DATA_WIDTH  head word; valid while empty=0.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read of an empty FIFO occurred.

Behaviour:

Reset (reset_b=0, asynchronous):
- wr_ptr=0, rd_ptr=0, count=0.
- empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
- Storage array is not reset.

Pointers:
- wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- full and empty are derived from count, not from pointer compare.

Acceptance, evaluated each cycle from current-cycle flags:
- rd_acc = rd_en & ~empty.
- wr_acc = wr_en & (~full | rd_acc). A write into a full FIFO is accepted when a pop is accepted in the same cycle.
- On wr_acc: mem[wr_ptr] <= din; wr_ptr increments.
- On rd_acc: rd_ptr increments.

Count update:
- count changes by +1 for wr_acc only, -1 for rd_acc only, 0 for both or neither.
- count never exceeds DEPTH and never goes below 0.

dout:
- Combinational read of mem[rd_ptr], forced to 0 when empty=1.
- Latency: a word written at edge N appears on dout with empty=0 after edge N, i.e. it is visible in cycle N+1.
- Order is strict FIFO.

Empty plus simultaneous wr_en and rd_en:
- The write is accepted; the read is rejected; underflow is set.
- count becomes 1.

Sticky errors:
- overflow <= 1 when wr_en & ~wr_acc.
- underflow <= 1 when rd_en & empty.
- Both hold until clr_err=1 or flush=1.
- If clr_err and a new error occur in the same cycle, set wins.

Flush:
- Highest priority over wr_en and rd_en.
- Next cycle: pointers=0, count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- wr_en and rd_en in the flush cycle are ignored and raise no error.

Status outputs:
- Registered-state derived: full, empty, almost_full and count reflect the state after the previous edge.
- No combinational path from wr_en or rd_en to full, empty or count.

Implementation:
- No state machine beyond the pointer/count datapath.
- Storage is a register array or distributed RAM; no BRAM output register, since FWFT must hold.

Test Plan:
- Reset then idle → empty=1, full=0, count=0, dout=0, overflow=0, underflow=0.
- Push 0xA5A5_0001 once, with rd_en low → next cycle: empty=0, count=1, dout=0xA5A5_0001. Pulse rd_en one cycle → empty=1, dout=0, count=0.
- Push 0x1..0x10 (16 words, DEPTH=16):
  - almost_full rises when count=12; full=1 after the 16th push.
  - A 17th push of 0xDEAD → overflow=1, count stays 16.
  - Pop all 16 → data reads 0x1..0x10 in order, and 0xDEAD never appears.
- Full FIFO, wr_en=1 (din=0x99) and rd_en=1 in the same cycle → count stays 16, overflow stays 0, head advances; 0x99 emerges last after 15 further pops.
- Pointer wrap:
  - Run 40 single push/pop pairs with data 0..39, keeping count ≤ 3 → every popped value matches in order across two pointer wraps.
  - Then rd_en on empty → underflow=1. Pulse clr_err → underflow=0.
- Five words loaded, then flush=1 with wr_en=1 and rd_en=1 in the same cycle → next cycle count=0, empty=1, no error flags. Assert reset_b=0 mid-push → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/spi_word_fifo.sv
// rtl/spi_word_fifo.sv - first-word-fall-through word FIFO between the AXI register slave and spi_controller
// Count-based full/empty; dout is a combinational read of the head so it is valid whenever empty=0.
module spi_word_fifo #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int DEPTH              = 16,
   parameter int AF_LEVEL           = 12
) (
   input  logic                          axi_clk,
   input  logic                          reset_b,
   input  logic                          flush,
   input  logic                          clr_err,
   input  logic                          wr_en,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] din,
   output logic                          full,
   output logic                          almost_full,
   input  logic                          rd_en,
   output logic [C_S_AXI_DATA_WIDTH-1:0] dout,
   output logic                          empty,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

   logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]                 wr_ptr;
   logic [AW-1:0]                 rd_ptr;
   logic                          rd_acc;
   logic                          wr_acc;
   logic                          wr_drop;
   logic                          rd_bad;

   assign empty       = (count == '0);
   assign full        = (count == DEPTH_C);
   assign almost_full = (count >= AF_C);
   assign dout        = empty ? '0 : mem[rd_ptr];

   // A push into a full FIFO still fits when the head is popped in the same cycle.
   assign rd_acc  = rd_en & ~empty & ~flush;
   assign wr_acc  = wr_en & (~full | rd_acc) & ~flush;
   assign wr_drop = wr_en & ~wr_acc & ~flush;
   assign rd_bad  = rd_en & empty & ~flush;

   always_ff @(posedge axi_clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge axi_clk or negedge reset_b) begin
      if (!reset_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Error flags: a new error in the same cycle as clr_err stays set.
   always_ff @(posedge axi_clk or negedge reset_b) begin
      if (!reset_b) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (flush) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_drop) begin
            overflow <= 1'b1;
         end else if (clr_err) begin
            overflow <= 1'b0;
         end
         if (rd_bad) begin
            underflow <= 1'b1;
         end else if (clr_err) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_word_fifo.sv
// tb/tb_spi_word_fifo.sv - directed and randomized bench for spi_word_fifo against a queue model
// Inputs are driven and outputs checked on the falling edge; the model advances on the rising edge.
module tb_spi_word_fifo;

   localparam int W     = 32;
   localparam int DEPTH = 16;
   localparam int AF    = 12;

   logic          axi_clk;
   logic          reset_b;
   logic          flush;
   logic          clr_err;
   logic          wr_en;
   logic [W-1:0]  din;
   logic          full;
   logic          almost_full;
   logic          rd_en;
   logic [W-1:0]  dout;
   logic          empty;
   logic [4:0]    count;
   logic          overflow;
   logic          underflow;

   logic [W-1:0]  model_q [$];
   bit            model_ovf;
   bit            model_udf;
   int            n_checks;
   int            n_fail;

   spi_word_fifo #(
      .C_S_AXI_DATA_WIDTH(W),
      .DEPTH(DEPTH),
      .AF_LEVEL(AF)
   ) dut (
      .axi_clk(axi_clk),
      .reset_b(reset_b),
      .flush(flush),
      .clr_err(clr_err),
      .wr_en(wr_en),
      .din(din),
      .full(full),
      .almost_full(almost_full),
      .rd_en(rd_en),
      .dout(dout),
      .empty(empty),
      .count(count),
      .overflow(overflow),
      .underflow(underflow)
   );

   initial axi_clk = 1'b0;
   always #5 axi_clk = ~axi_clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int sz;
      sz = model_q.size();
      check("count", W'(count), W'(sz));
      check("empty", W'(empty), W'(sz == 0));
      check("full", W'(full), W'(sz == DEPTH));
      check("almost_full", W'(almost_full), W'(sz >= AF));
      check("dout", dout, (sz == 0) ? '0 : model_q[0]);
      check("overflow", W'(overflow), W'(model_ovf));
      check("underflow", W'(underflow), W'(model_udf));
   endtask

   task automatic model_step(input bit wr, input bit rd, input logic [W-1:0] d,
                             input bit fl, input bit ce);
      bit rd_ok;
      bit wr_ok;
      int sz;
      if (fl) begin
         model_q.delete();
         model_ovf = 0;
         model_udf = 0;
      end else begin
         sz    = model_q.size();
         rd_ok = rd && (sz > 0);
         wr_ok = wr && ((sz < DEPTH) || rd_ok);
         if (rd_ok) void'(model_q.pop_front());
         if (wr_ok) model_q.push_back(d);
         if (wr && !wr_ok) model_ovf = 1;
         else if (ce) model_ovf = 0;
         if (rd && sz == 0) model_udf = 1;
         else if (ce) model_udf = 0;
      end
   endtask

   task automatic cyc(input bit wr, input bit rd, input logic [W-1:0] d,
                      input bit fl, input bit ce);
      @(negedge axi_clk);
      check_all();
      wr_en   = wr;
      rd_en   = rd;
      din     = d;
      flush   = fl;
      clr_err = ce;
      @(posedge axi_clk);
      model_step(wr, rd, d, fl, ce);
   endtask

   task automatic idle();
      cyc(0, 0, '0, 0, 0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_ovf = 0;
      model_udf = 0;
      reset_b = 1'b0;
      flush   = 1'b0;
      clr_err = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      din     = '0;
      repeat (3) @(negedge axi_clk);
      check_all();
      reset_b = 1'b1;
      idle();

      // single word round trip
      cyc(1, 0, 32'hA5A5_0001, 0, 0);
      cyc(0, 1, '0, 0, 0);
      idle();

      // fill, overflow, drain
      for (int i = 1; i <= DEPTH; i++) cyc(1, 0, W'(i), 0, 0);
      cyc(1, 0, 32'hDEAD, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, '0, 0, 0);
      cyc(0, 0, '0, 0, 1);

      // simultaneous push/pop while full
      for (int i = 0; i < DEPTH; i++) cyc(1, 0, W'(32'h100 + i), 0, 0);
      cyc(1, 1, 32'h99, 0, 0);
      for (int i = 0; i < DEPTH; i++) cyc(0, 1, '0, 0, 0);
      idle();

      // pointer wrap, then underflow and its clear
      for (int i = 0; i < 40; i++) begin
         cyc(1, 0, W'(i), 0, 0);
         cyc(0, 1, '0, 0, 0);
      end
      cyc(0, 1, '0, 0, 0);
      cyc(1, 1, 32'h77, 0, 0);
      cyc(0, 0, '0, 0, 1);
      cyc(0, 1, '0, 0, 1);
      idle();

      // flush with concurrent push/pop
      for (int i = 0; i < 5; i++) cyc(1, 0, W'(32'h500 + i), 0, 0);
      cyc(1, 1, 32'hBAD, 1, 0);
      idle();

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         cyc(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 45), $urandom(),
             ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0));
      end

      // asynchronous reset in the middle of a push
      for (int i = 0; i < 5; i++) cyc(1, 0, W'(32'h600 + i), 0, 0);
      @(negedge axi_clk);
      check_all();
      wr_en = 1'b1;
      din   = 32'hC0DE;
      #2 reset_b = 1'b0;
      #1;
      model_q.delete();
      model_ovf = 0;
      model_udf = 0;
      check_all();
      @(negedge axi_clk);
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      flush   = 1'b0;
      clr_err = 1'b0;
      check_all();
      reset_b = 1'b1;
      idle();
      cyc(1, 0, 32'h1234, 0, 0);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
